// File: rtl/msi_irq_arbiter_pkg.sv
// Shared types and helpers for the MSI interrupt arbiter.
// Holds the arbiter FSM state encoding and the vector-width function.
// Used by the interface, the round-robin picker and the top level.
package pkg_msi_irq;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLDOFF = 2'd2
  } msi_state_e;

  // Width of a source index, never narrower than one bit.
  function automatic int calc_vec_w(input int n_src);
    if (n_src <= 2) return 1;
    return $clog2(n_src);
  endfunction

endpackage

// File: rtl/msi_irq_arbiter_if.sv
// MSI request/grant handshake between the arbiter and the PCIe core.
// Carries the enable, the request/vector pair and the single-cycle grant.
// master = arbiter side, slave = PCIe core side.
interface msi_irq_arbiter_if
  import pkg_msi_irq::*;
#(
  parameter int N_SRC = 4
);
  localparam int VEC_W = calc_vec_w(N_SRC);

  logic             msi_enabled_i;
  logic             msi_request_o;
  logic [VEC_W-1:0] msi_vector_o;
  logic             msi_grant_i;

  modport master (
    input  msi_enabled_i,
    input  msi_grant_i,
    output msi_request_o,
    output msi_vector_o
  );

  modport slave (
    output msi_enabled_i,
    output msi_grant_i,
    input  msi_request_o,
    input  msi_vector_o
  );
endinterface

// File: rtl/msi_irq_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last_i+1 (mod N_SRC).
// Latency: purely combinational.
// Backpressure: none; vld_o low when no request bit is set.
// Ports: req_i (request vector), last_i (last served index),
//        grant_oh_o / grant_idx_o (chosen source), vld_o (a source was chosen).
module rr_pick
  import pkg_msi_irq::*;
#(
  parameter  int N_SRC = 4,
  localparam int VEC_W = calc_vec_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [VEC_W-1:0] last_i,
  output logic [N_SRC-1:0] grant_oh_o,
  output logic [VEC_W-1:0] grant_idx_o,
  output logic             vld_o
);

  logic [VEC_W-1:0] cand;

  // Walk the candidates from farthest to nearest so the nearest hit is the
  // last assignment and wins; the modulo keeps cand inside 0..N_SRC-1.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    vld_o       = 1'b0;
    cand        = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      cand = VEC_W'((int'(last_i) + i) % N_SRC);
      if (req_i[cand]) begin
        grant_oh_o       = '0;
        grant_oh_o[cand] = 1'b1;
        grant_idx_o      = cand;
        vld_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_irq_arbiter.sv
// Collects per-source interrupt edges into pending bits and issues MSI requests round-robin.
// Latency: 2 cycles from a new irq_i level to msi_request_o (idle, no competition).
// Backpressure: request/vector held until msi_grant_i; dropping msi_enabled_i re-queues the source.
// Ports: aclk, aresetn (async active-low), irq_i, msi (request/vector/grant/enable handshake),
//        pending_o, overflow_o (sticky), ovf_clr_i.
// Optional macro MSI_IRQ_MASK_EN adds irq_mask_i: masked sources still latch but are not selected.
module msi_irq_arbiter
  import pkg_msi_irq::*;
#(
  parameter  int N_SRC       = 4,
  parameter  int HOLDOFF_CYC = 0,
  localparam int VEC_W       = calc_vec_w(N_SRC)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [N_SRC-1:0] irq_i,
`ifdef MSI_IRQ_MASK_EN
  input  logic [N_SRC-1:0] irq_mask_i,
`endif
  msi_irq_arbiter_if.master msi,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] overflow_o,
  input  logic             ovf_clr_i
);

  // Counter is loaded with N-1 so that exactly HOLDOFF_CYC cycles are spent in HOLDOFF.
  localparam logic [15:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? 16'(HOLDOFF_CYC - 1) : 16'd0;

  msi_state_e       state, state_nxt;
  logic [N_SRC-1:0] irq_q, rise, eligible, ovf_evt;
  logic [N_SRC-1:0] pick_oh, clr_mask, restore_mask;
  logic [VEC_W-1:0] pick_idx, vec_nxt, last_vec, last_nxt;
  logic             pick_vld, req_nxt;
  logic [15:0]      hold_cnt, hold_nxt;

  assign rise = irq_i & ~irq_q;

`ifdef MSI_IRQ_MASK_EN
  assign eligible = pending_o & ~irq_mask_i;
`else
  assign eligible = pending_o;
`endif

  // An edge on a bit being cleared this cycle just re-arms it, so it is not an overflow.
  assign ovf_evt = rise & pending_o & ~clr_mask;

  rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
    .req_i       (eligible),
    .last_i      (last_vec),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .vld_o       (pick_vld)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_nxt      = msi.msi_request_o;
    vec_nxt      = msi.msi_vector_o;
    last_nxt     = last_vec;
    hold_nxt     = hold_cnt;
    clr_mask     = '0;
    restore_mask = '0;
    unique case (state)
      ST_IDLE: begin
        if (msi.msi_enabled_i && pick_vld) begin
          clr_mask  = pick_oh;
          vec_nxt   = pick_idx;
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Grant takes priority over a simultaneous disable.
        if (msi.msi_grant_i) begin
          req_nxt  = 1'b0;
          last_nxt = msi.msi_vector_o;
          if (HOLDOFF_CYC > 0) begin
            hold_nxt  = HOLD_LOAD;
            state_nxt = ST_HOLDOFF;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (!msi.msi_enabled_i) begin
          // Abandoned request: put the source back in the pending set.
          req_nxt      = 1'b0;
          restore_mask = N_SRC'(1) << msi.msi_vector_o;
          state_nxt    = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == '0) state_nxt = ST_IDLE;
        else                hold_nxt  = hold_cnt - 16'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_q             <= '0;
      pending_o         <= '0;
      overflow_o        <= '0;
      msi.msi_request_o <= 1'b0;
      msi.msi_vector_o  <= '0;
      last_vec          <= VEC_W'(N_SRC - 1);
      hold_cnt          <= '0;
    end else begin
      irq_q             <= irq_i;
      pending_o         <= (pending_o & ~clr_mask) | rise | restore_mask;
      // A new overflow event beats a clear in the same cycle.
      overflow_o        <= (ovf_clr_i ? '0 : overflow_o) | ovf_evt;
      msi.msi_request_o <= req_nxt;
      msi.msi_vector_o  <= vec_nxt;
      last_vec          <= last_nxt;
      hold_cnt          <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Testbench for msi_irq_arbiter: directed scenarios plus a randomized run against a reference model.
// Runs with N_SRC=4, HOLDOFF_CYC=8.
// Prints one summary line at the end.
module tb_msi_irq_arbiter;
  import pkg_msi_irq::*;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [N-1:0] irq = '0;
  logic [N-1:0] pending, overflow;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] mask_eff;
`ifdef MSI_IRQ_MASK_EN
  logic [N-1:0] mask = '0;
  assign mask_eff = mask;
`else
  assign mask_eff = '0;
`endif

  int checks = 0;
  int errors = 0;

  msi_irq_arbiter_if #(.N_SRC(N)) msi ();

  msi_irq_arbiter #(.N_SRC(N), .HOLDOFF_CYC(HOLD)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .irq_i      (irq),
`ifdef MSI_IRQ_MASK_EN
    .irq_mask_i (mask),
`endif
    .msi        (msi),
    .pending_o  (pending),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr)
  );

  always #5 aclk = ~aclk;

  // Reference model: one step per clock, using the documented rules directly.
  logic [N-1:0] m_pend, m_ovf, m_prev, m_old;
  bit           m_req, m_edge;
  int           m_vec, m_last, m_earliest, cyc, m_cleared, m_restore, m_s;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_pend = '0; m_ovf = '0; m_prev = '0; m_req = 0;
      m_vec = 0; m_last = N - 1; m_earliest = 0; cyc = 0;
    end else begin
      cyc++;
      m_old = m_pend; m_cleared = -1; m_restore = -1;
      if (m_req) begin
        if (msi.msi_grant_i) begin
          m_req = 0; m_last = m_vec; m_earliest = cyc + HOLD + 1;
        end else if (!msi.msi_enabled_i) begin
          m_req = 0; m_restore = m_vec;
        end
      end else if (msi.msi_enabled_i && cyc >= m_earliest) begin
        for (int i = 1; i <= N; i++) begin
          m_s = (m_last + i) % N;
          if (m_cleared < 0 && m_old[m_s] && !mask_eff[m_s]) m_cleared = m_s;
        end
        if (m_cleared >= 0) begin m_req = 1; m_vec = m_cleared; end
      end
      if (ovf_clr) m_ovf = '0;
      for (int k = 0; k < N; k++) begin
        m_edge = irq[k] && !m_prev[k];
        if (k == m_cleared)      m_pend[k] = m_edge;
        else if (k == m_restore) m_pend[k] = 1'b1;
        else if (m_edge) begin
          if (m_old[k]) m_ovf[k] = 1'b1;
          m_pend[k] = 1'b1;
        end
      end
      m_prev = irq;
    end
  end

  task automatic do_reset();
    aresetn = 1'b0; irq = '0; ovf_clr = 1'b0;
    msi.msi_grant_i = 1'b0; msi.msi_enabled_i = 1'b1;
`ifdef MSI_IRQ_MASK_EN
    mask = '0;
`endif
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Waits at negedges for a request, up to budget cycles.
  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (msi.msi_request_o) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; msi.msi_grant_i = 1'b0; msi.msi_enabled_i = 1'b1;
    @(posedge aclk); #1;
    checks++; if (msi.msi_request_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", msi.msi_request_o); end
    checks++; if (msi.msi_vector_o !== 2'd0) begin errors++; $display("FAIL reset_vec got %0d want 0", msi.msi_vector_o); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL reset_pend got %b want 0000", pending); end
    checks++; if (overflow !== 4'b0) begin errors++; $display("FAIL reset_ovf got %b want 0000", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    irq = 4'b0100;
    @(negedge aclk);
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pend1 got %b want 0100", pending); end
    checks++; if (msi.msi_request_o !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", msi.msi_request_o); end
    @(negedge aclk);
    checks++; if (msi.msi_request_o !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", msi.msi_request_o); end
    checks++; if (msi.msi_vector_o !== 2'd2) begin errors++; $display("FAIL single_vec got %0d want 2", msi.msi_vector_o); end
    @(negedge aclk);
    checks++; if (msi.msi_request_o !== 1'b1 || msi.msi_vector_o !== 2'd2) begin
      errors++; $display("FAIL single_hold got req %b vec %0d want 1/2", msi.msi_request_o, msi.msi_vector_o); end
    msi.msi_grant_i = 1'b1;
    @(negedge aclk);
    msi.msi_grant_i = 1'b0;
    checks++; if (msi.msi_request_o !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", msi.msi_request_o); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL single_pend2 got %b want 0000", pending); end
    irq = '0;
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    irq = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_req(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_timeout got none want req %0d", i); end
      checks++; if (msi.msi_vector_o !== 2'(i)) begin errors++; $display("FAIL fair_order got %0d want %0d", msi.msi_vector_o, i); end
      msi.msi_grant_i = 1'b1;
      @(negedge aclk);
      msi.msi_grant_i = 1'b0;
    end
    irq = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    msi.msi_enabled_i = 1'b0;
    irq = 4'b0010; @(negedge aclk);
    irq = 4'b0000; @(negedge aclk);
    irq = 4'b0010; @(negedge aclk);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovf_pend got %b want 0010", pending); end
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set got %b want 0010", overflow); end
    ovf_clr = 1'b1; @(negedge aclk); ovf_clr = 1'b0;
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clr got %b want 0000", overflow); end
    irq = 4'b0000; @(negedge aclk);
    irq = 4'b0010; ovf_clr = 1'b1; @(negedge aclk); ovf_clr = 1'b0;
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_race got %b want 0010", overflow); end
    irq = '0;
  endtask

  task automatic test_holdoff();
    bit ok;
    int n;
    do_reset();
    irq = 4'b0011;
    wait_req(10, ok);
    checks++; if (!ok || msi.msi_vector_o !== 2'd0) begin errors++; $display("FAIL hold_first got ok %b vec %0d want 1/0", ok, msi.msi_vector_o); end
    msi.msi_grant_i = 1'b1;
    @(negedge aclk);
    msi.msi_grant_i = 1'b0;
    n = 0;
    while (!msi.msi_request_o && n < 30) begin @(negedge aclk); n++; end
    checks++; if (n != HOLD + 1) begin errors++; $display("FAIL hold_gap got %0d want %0d", n, HOLD + 1); end
    checks++; if (msi.msi_vector_o !== 2'd1) begin errors++; $display("FAIL hold_vec got %0d want 1", msi.msi_vector_o); end
    irq = '0;
  endtask

  task automatic test_disable();
    bit ok, seen;
    do_reset();
    irq = 4'b1000;
    wait_req(10, ok);
    checks++; if (!ok || msi.msi_vector_o !== 2'd3) begin errors++; $display("FAIL dis_first got ok %b vec %0d want 1/3", ok, msi.msi_vector_o); end
    msi.msi_enabled_i = 1'b0;
    @(negedge aclk);
    checks++; if (msi.msi_request_o !== 1'b0) begin errors++; $display("FAIL dis_drop got %b want 0", msi.msi_request_o); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL dis_pend got %b want 1000", pending); end
    seen = 1'b0;
    repeat (5) begin @(negedge aclk); if (msi.msi_request_o) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL dis_quiet got req want none"); end
    msi.msi_enabled_i = 1'b1;
    wait_req(5, ok);
    checks++; if (!ok || msi.msi_vector_o !== 2'd3) begin errors++; $display("FAIL dis_resume got ok %b vec %0d want 1/3", ok, msi.msi_vector_o); end
    irq = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    irq = 4'b1100;
    wait_req(10, ok);
    checks++; if (!ok || msi.msi_vector_o !== 2'd2 || pending !== 4'b1000) begin
      errors++; $display("FAIL rmid_setup got ok %b vec %0d pend %b want 1/2/1000", ok, msi.msi_vector_o, pending); end
    aresetn = 1'b0;
    #1;
    checks++; if (msi.msi_request_o !== 1'b0 || msi.msi_vector_o !== 2'd0 || pending !== 4'b0) begin
      errors++; $display("FAIL rmid_clear got req %b vec %0d pend %b want 0/0/0000", msi.msi_request_o, msi.msi_vector_o, pending); end
    irq = '0;
  endtask

`ifdef MSI_IRQ_MASK_EN
  task automatic test_mask();
    bit ok, seen;
    do_reset();
    mask = 4'b0001;
    irq = 4'b0001;
    seen = 1'b0;
    repeat (5) begin @(negedge aclk); if (msi.msi_request_o) seen = 1'b1; end
    checks++; if (seen || pending !== 4'b0001) begin errors++; $display("FAIL mask_hold got req %b pend %b want 0/0001", seen, pending); end
    mask = 4'b0000;
    wait_req(5, ok);
    checks++; if (!ok || msi.msi_vector_o !== 2'd0) begin errors++; $display("FAIL mask_release got ok %b vec %0d want 1/0", ok, msi.msi_vector_o); end
    irq = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge aclk);
      checks++; if (msi.msi_request_o !== m_req) begin errors++; $display("FAIL rnd_req c=%0d got %b want %b", c, msi.msi_request_o, m_req); end
      checks++; if (msi.msi_vector_o !== 2'(m_vec)) begin errors++; $display("FAIL rnd_vec c=%0d got %0d want %0d", c, msi.msi_vector_o, m_vec); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d got %b want %b", c, pending, m_pend); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow, m_ovf); end
      for (int k = 0; k < N; k++) if ($urandom_range(5) == 0) irq[k] = ~irq[k];
      msi.msi_enabled_i = ($urandom_range(15) != 0);
      msi.msi_grant_i   = msi.msi_request_o ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      ovf_clr           = ($urandom_range(19) == 0);
`ifdef MSI_IRQ_MASK_EN
      if ($urandom_range(15) == 0) mask = 4'($urandom_range(15));
`endif
    end
    msi.msi_grant_i = 1'b0; ovf_clr = 1'b0; irq = '0;
  endtask

  initial begin
    msi.msi_grant_i = 1'b0;
    msi.msi_enabled_i = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_holdoff();
    test_disable();
    test_reset_mid();
`ifdef MSI_IRQ_MASK_EN
    test_mask();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
